// File: rtl/data_io_dma_if.sv
// SPI input pins and RAM write port of the file-download DMA.
interface data_io_dma_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 8
);
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_sdi;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_ack;

    // DMA side: listens to SPI, issues RAM writes
    modport master (
        input  spi_sck, spi_ss, spi_sdi, ram_ack,
        output ram_wr, ram_addr, ram_data
    );

    // host side: drives SPI, accepts RAM writes
    modport slave (
        output spi_sck, spi_ss, spi_sdi, ram_ack,
        input  ram_wr, ram_addr, ram_data
    );
endinterface

// File: rtl/data_io_dma.sv
// File-download port: oversampled SPI command receiver, byte-to-word packer,
// write FIFO towards RAM and optional zero-fill of a region after a download.
module data_io_dma #(
    parameter int          ADDR_W     = 25,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned BASE_IDX0  = 'h040000,
    parameter int unsigned BASE_OTHER = 'h200000,
    parameter int unsigned ERASE_TRIG = 'h2000,
    parameter int unsigned ERASE_BASE = 'h060000,
    parameter int unsigned ERASE_LEN  = 'h2000
) (
    input  logic              clk,
    input  logic              reset,
    data_io_dma_if.master     bus,
    output logic              downloading,
    output logic              erasing,
    output logic              overflow,
    output logic [4:0]        index,
    output logic [ADDR_W-1:0] size
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CMD_TX  = 8'h53;
    localparam logic [7:0] CMD_DAT = 8'h54;
    localparam logic [7:0] CMD_IDX = 8'h55;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] STEP_L   = (ADDR_W+1)'(DATA_W / 8);
    localparam logic [ADDR_W:0] ER_LEN   = (ADDR_W+1)'(ERASE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DL, S_FLUSH, S_ERASE} state_t;
    state_t state;

    // ---------------- SPI oversampling ----------------
    logic [2:0] sck_s;
    logic [1:0] ss_s, sdi_s;
    logic       sck_rise;

    // two-stage synchronisers; third sck stage gives the rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s <= '0;
            ss_s  <= '1;
            sdi_s <= '0;
        end else begin
            sck_s <= {sck_s[1:0], bus.spi_sck};
            ss_s  <= {ss_s[0], bus.spi_ss};
            sdi_s <= {sdi_s[0], bus.spi_sdi};
        end
    end
    assign sck_rise = sck_s[1] & ~sck_s[2];

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       have_cmd;
    logic [7:0] cmd, rx_byte, rx_cmd;
    logic       rx_vld;

    // MSB-first byte assembly; first byte of a select is the command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0; shreg <= '0; have_cmd <= 1'b0; cmd <= '0;
            rx_vld <= 1'b0; rx_byte <= '0; rx_cmd <= '0;
        end else begin
            rx_vld <= 1'b0;
            if (ss_s[1]) begin
                bit_cnt <= '0; have_cmd <= 1'b0; cmd <= '0;
            end else if (sck_rise) begin
                shreg   <= {shreg[5:0], sdi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (!have_cmd) begin
                        cmd      <= {shreg, sdi_s[1]};
                        have_cmd <= 1'b1;
                    end else begin
                        rx_vld  <= 1'b1;
                        rx_byte <= {shreg, sdi_s[1]};
                        rx_cmd  <= cmd;
                    end
                end
            end
        end
    end

    // ---------------- download datapath ----------------
    logic              is_start, is_end, is_dat;
    logic [ADDR_W-1:0] addr, er_addr, word_addr;
    logic [ADDR_W:0]   er_left;
    logic              pend;
    logic [7:0]        pend_byte;
    logic [DATA_W-1:0] dat_word, end_word, push_data;

    assign is_start = rx_vld && rx_cmd == CMD_TX && rx_byte[0];
    assign is_end   = rx_vld && rx_cmd == CMD_TX && !rx_byte[0] && state == S_DL;
    assign is_dat   = rx_vld && rx_cmd == CMD_DAT && state == S_DL;

    // 16-bit words are little-endian pairs at the even address
    if (DATA_W == 16) begin : g_w16
        assign dat_word  = {rx_byte, pend_byte};
        assign end_word  = {8'h00, pend_byte};
        assign word_addr = {addr[ADDR_W-1:1], 1'b0};
    end else begin : g_w8
        assign dat_word  = rx_byte;
        assign end_word  = pend_byte;
        assign word_addr = addr;
    end

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp, rp;
    logic [PTR_W:0]    count;
    logic              want_push, do_push, drop, pop;

    assign want_push = (is_dat && (DATA_W == 8 || addr[0])) || (is_end && pend);
    assign push_data = is_end ? end_word : dat_word;
    assign pop       = bus.ram_wr && bus.ram_ack && !erasing;
    // a pop on the same clk frees the slot, so a full FIFO still accepts
    assign do_push   = want_push && (count != FULL_CNT || pop);
    assign drop      = want_push && !do_push;

    assign bus.ram_wr   = erasing || count != '0;
    assign bus.ram_addr = erasing ? er_addr : (count != '0 ? mem_addr[rp] : '0);
    assign bus.ram_data = (!erasing && count != '0) ? mem_data[rp] : '0;

    // control FSM, FIFO pointers and download bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            downloading <= 1'b0; erasing <= 1'b0; overflow <= 1'b0;
            index <= '0; size <= '0; addr <= '0;
            er_addr <= '0; er_left <= '0;
            pend <= 1'b0; pend_byte <= '0;
            wp <= '0; rp <= '0; count <= '0;
        end else begin
            if (pop)
                rp <= rp + PTR_W'(1);
            if (do_push) begin
                mem_addr[wp] <= word_addr;
                mem_data[wp] <= push_data;
                wp <= wp + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
            if (drop)
                overflow <= 1'b1;
            if (rx_vld && rx_cmd == CMD_IDX)
                index <= rx_byte[4:0];

            case (state)
                S_DL: begin
                    if (is_dat) begin
                        addr <= addr + ADDR_W'(1);
                        if (size != '1)
                            size <= size + ADDR_W'(1);
                        pend <= (DATA_W == 16) && !addr[0];
                        if (!addr[0])
                            pend_byte <= rx_byte;
                    end else if (is_end) begin
                        pend  <= 1'b0;
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (count == '0) begin
                        downloading <= 1'b0;
                        if (index == 5'd0 && size == ADDR_W'(ERASE_TRIG) && ER_LEN != '0) begin
                            state   <= S_ERASE;
                            erasing <= 1'b1;
                            er_addr <= ADDR_W'(ERASE_BASE);
                            er_left <= ER_LEN;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_ERASE: begin
                    if (bus.ram_wr && bus.ram_ack) begin
                        er_addr <= er_addr + ADDR_W'(DATA_W / 8);
                        if (er_left <= STEP_L) begin
                            erasing <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            er_left <= er_left - STEP_L;
                        end
                    end
                end
                default: ;
            endcase

            // a new transfer overrides whatever was running
            if (is_start) begin
                state <= S_DL;
                addr <= (index == 5'd0) ? ADDR_W'(BASE_IDX0) : ADDR_W'(BASE_OTHER);
                size <= '0; overflow <= 1'b0;
                downloading <= 1'b1; erasing <= 1'b0;
                wp <= '0; rp <= '0; count <= '0; pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_io_dma.sv
// Directed bench: one 8-bit and one 16-bit instance share the SPI stream.
module tb_data_io_dma;
    logic clk, reset;
    logic sck, ss, sdi, ack8, ack16;
    logic dl8, er8, ov8, dl16, er16, ov16;
    logic [4:0]  idx8, idx16;
    logic [24:0] sz8, sz16;
    int n_cmp = 0, n_fail = 0;

    data_io_dma_if #(.ADDR_W(25), .DATA_W(8))  if8 ();
    data_io_dma_if #(.ADDR_W(25), .DATA_W(16)) if16 ();

    assign if8.spi_sck = sck;  assign if8.spi_ss = ss;  assign if8.spi_sdi = sdi;
    assign if16.spi_sck = sck; assign if16.spi_ss = ss; assign if16.spi_sdi = sdi;
    assign if8.ram_ack = ack8; assign if16.ram_ack = ack16;

    data_io_dma #(.ADDR_W(25), .DATA_W(8), .FIFO_DEPTH(4),
                  .ERASE_TRIG(16), .ERASE_BASE('h060000), .ERASE_LEN(16)) dut8 (
        .clk(clk), .reset(reset), .bus(if8), .downloading(dl8), .erasing(er8),
        .overflow(ov8), .index(idx8), .size(sz8));

    data_io_dma #(.ADDR_W(25), .DATA_W(16), .FIFO_DEPTH(4),
                  .ERASE_TRIG(16), .ERASE_BASE('h060000), .ERASE_LEN(16)) dut16 (
        .clk(clk), .reset(reset), .bus(if16), .downloading(dl16), .erasing(er16),
        .overflow(ov16), .index(idx16), .size(sz16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] w8a[$], w16a[$];
    logic [7:0]  w8d[$];
    logic [15:0] w16d[$];
    logic [7:0]  txb[$];
    bit er8_seen;

    // write log, sampled half a cycle before the accepting edge
    always @(negedge clk) begin
        if (if8.ram_wr && if8.ram_ack) begin w8a.push_back(if8.ram_addr); w8d.push_back(if8.ram_data); end
        if (if16.ram_wr && if16.ram_ack) begin w16a.push_back(if16.ram_addr); w16d.push_back(if16.ram_data); end
        if (er8) er8_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sdi = b[i]; tick(3); sck = 1'b1; tick(3); sck = 1'b0;
        end
    endtask

    task automatic spi_cmd(input logic [7:0] c, input logic [7:0] d);
        ss = 1'b0; tick(3); spi_byte(c); spi_byte(d); tick(3); ss = 1'b1; tick(4);
    endtask

    task automatic send_data();
        ss = 1'b0; tick(3); spi_byte(8'h54);
        foreach (txb[i]) spi_byte(txb[i]);
        tick(3); ss = 1'b1; tick(4);
    endtask

    task automatic clear_log();
        w8a.delete(); w8d.delete(); w16a.delete(); w16d.delete();
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!dl8 && !dl16) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_erase_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!er8 && !er16) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(3); @(negedge clk);
        n_cmp++;
        if ({dl8, er8, ov8, idx8, sz8, if8.ram_wr, if8.ram_addr, if8.ram_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs8: got nonzero want all 0");
        end
        n_cmp++;
        if ({dl16, er16, ov16, idx16, sz16, if16.ram_wr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs16: got nonzero want all 0");
        end
        @(negedge clk); reset = 1'b0; tick(4);
    endtask

    task automatic test_dl8();
        logic [7:0] exp8 [3] = '{8'h11, 8'h22, 8'h33};
        bit ok;
        spi_cmd(8'h55, 8'h01); spi_cmd(8'h53, 8'h01);
        @(negedge clk);
        n_cmp++; if (dl8 !== 1'b1 || idx8 !== 5'd1) begin n_fail++; $display("FAIL dl8_start: got dl=%0b idx=%0d want 1 1", dl8, idx8); end
        tick(1); clear_log();
        txb = '{8'h11, 8'h22, 8'h33}; send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL dl8_idle_timeout: got busy want idle"); end
        n_cmp++;
        if (w8a.size() != 3) begin n_fail++; $display("FAIL dl8_nwr: got %0d want 3", w8a.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (w8a[i] !== 25'h200000 + 25'(i) || w8d[i] !== exp8[i]) begin
                n_fail++; $display("FAIL dl8_wr%0d: got %0h=%0h want %0h=%0h", i, w8a[i], w8d[i], 25'h200000 + 25'(i), exp8[i]);
            end
        end
        n_cmp++; if (sz8 !== 25'd3) begin n_fail++; $display("FAIL dl8_size: got %0d want 3", sz8); end
    endtask

    task automatic test_dl16();
        bit ok;
        spi_cmd(8'h53, 8'h01); clear_log();
        txb = '{8'hAA, 8'hBB, 8'hCC}; send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL dl16_idle_timeout: got busy want idle"); end
        n_cmp++;
        if (w16a.size() != 2) begin n_fail++; $display("FAIL dl16_nwr: got %0d want 2", w16a.size()); end
        else begin
            n_cmp++;
            if (w16a[0] !== 25'h200000 || w16d[0] !== 16'hBBAA) begin n_fail++; $display("FAIL dl16_wr0: got %0h=%0h want 200000=bbaa", w16a[0], w16d[0]); end
            n_cmp++;
            if (w16a[1] !== 25'h200002 || w16d[1] !== 16'h00CC) begin n_fail++; $display("FAIL dl16_wr1: got %0h=%0h want 200002=cc", w16a[1], w16d[1]); end
        end
        n_cmp++; if (sz16 !== 25'd3) begin n_fail++; $display("FAIL dl16_size: got %0d want 3", sz16); end
    endtask

    task automatic test_overflow();
        bit ok;
        ack8 = 1'b0;
        spi_cmd(8'h53, 8'h01); clear_log();
        txb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_data();
        @(negedge clk);
        n_cmp++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", ov8); end
        n_cmp++; if (sz8 !== 25'd5) begin n_fail++; $display("FAIL ovf_size: got %0d want 5", sz8); end
        n_cmp++; if (if8.ram_wr !== 1'b1 || w8a.size() != 0) begin n_fail++; $display("FAIL ovf_held: got wr=%0b n=%0d want 1 0", if8.ram_wr, w8a.size()); end
        n_cmp++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL ovf16_flag: got %0b want 0", ov16); end
        tick(1); ack8 = 1'b1;
        spi_cmd(8'h53, 8'h00);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_idle_timeout: got busy want idle"); end
        n_cmp++;
        if (w8a.size() != 4) begin n_fail++; $display("FAIL ovf_nwr: got %0d want 4", w8a.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (w8a[i] !== 25'h200000 + 25'(i) || w8d[i] !== 8'(i + 1)) begin
                n_fail++; $display("FAIL ovf_wr%0d: got %0h=%0h want %0h=%0h", i, w8a[i], w8d[i], 25'h200000 + 25'(i), i + 1);
            end
        end
        tick(1);
        spi_cmd(8'h53, 8'h01); @(negedge clk);
        n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", ov8); end
        tick(1); spi_cmd(8'h53, 8'h00);
        wait_idle(200, ok);
    endtask

    task automatic test_erase();
        bit ok;
        int nz, bad;
        spi_cmd(8'h55, 8'h00); spi_cmd(8'h53, 8'h01); clear_log(); er8_seen = 1'b0;
        txb.delete(); for (int i = 0; i < 16; i++) txb.push_back(8'h80 + 8'(i));
        send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(300, ok);
        wait_erase_done(300, ok);
        n_cmp++; if (!ok || !er8_seen) begin n_fail++; $display("FAIL erase_run: got done=%0b seen=%0b want 1 1", ok, er8_seen); end
        nz = 0; bad = 0;
        foreach (w8a[i]) if (w8a[i] >= 25'h060000) begin
            if (w8a[i] !== 25'h060000 + 25'(nz) || w8d[i] !== 8'h00) bad++;
            nz++;
        end
        n_cmp++; if (nz != 16 || bad != 0) begin n_fail++; $display("FAIL erase8_words: got n=%0d bad=%0d want 16 0", nz, bad); end
        nz = 0; bad = 0;
        foreach (w16a[i]) if (w16a[i] >= 25'h060000) begin
            if (w16a[i] !== 25'h060000 + 25'(2 * nz) || w16d[i] !== 16'h0000) bad++;
            nz++;
        end
        n_cmp++; if (nz != 8 || bad != 0) begin n_fail++; $display("FAIL erase16_words: got n=%0d bad=%0d want 8 0", nz, bad); end
        // one byte short of the trigger: no erase
        tick(1); spi_cmd(8'h53, 8'h01); clear_log(); er8_seen = 1'b0;
        void'(txb.pop_back()); send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(300, ok); tick(20);
        nz = 0; foreach (w8a[i]) if (w8a[i] >= 25'h060000) nz++;
        n_cmp++; if (er8_seen || nz != 0 || sz8 !== 25'd15) begin n_fail++; $display("FAIL no_erase: got seen=%0b nz=%0d size=%0d want 0 0 15", er8_seen, nz, sz8); end
    endtask

    task automatic test_abort();
        bit ok;
        spi_cmd(8'h53, 8'h01);
        txb.delete(); for (int i = 0; i < 16; i++) txb.push_back(8'h40 + 8'(i));
        send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(300, ok);
        n_cmp++; if (!ok || er8 !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got idle=%0b er=%0b want 1 1", ok, er8); end
        tick(4); ack8 = 1'b0;
        spi_cmd(8'h53, 8'h01); @(negedge clk);
        n_cmp++; if (er8 !== 1'b0 || dl8 !== 1'b1 || if8.ram_wr !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got er=%0b dl=%0b wr=%0b want 0 1 0", er8, dl8, if8.ram_wr);
        end
        tick(1); clear_log(); ack8 = 1'b1; tick(20); @(negedge clk);
        n_cmp++; if (w8a.size() != 0) begin n_fail++; $display("FAIL abort_nowr: got %0d want 0", w8a.size()); end
        tick(1); txb = '{8'h77}; send_data(); spi_cmd(8'h53, 8'h00);
        wait_idle(200, ok);
        n_cmp++;
        if (w8a.size() != 1) begin n_fail++; $display("FAIL abort_reload_n: got %0d want 1", w8a.size()); end
        else if (w8a[0] !== 25'h040000 || w8d[0] !== 8'h77) begin
            n_fail++; $display("FAIL abort_reload: got %0h=%0h want 40000=77", w8a[0], w8d[0]);
        end
    endtask

    task automatic test_reset_mid();
        spi_cmd(8'h55, 8'h03); spi_cmd(8'h53, 8'h01);
        ack8 = 1'b0; txb = '{8'hA1, 8'hA2}; send_data(); @(negedge clk);
        n_cmp++; if (dl8 !== 1'b1 || if8.ram_wr !== 1'b1 || idx8 !== 5'd3) begin
            n_fail++; $display("FAIL rmid_pre: got dl=%0b wr=%0b idx=%0d want 1 1 3", dl8, if8.ram_wr, idx8);
        end
        reset = 1'b1; #1;
        n_cmp++;
        if ({dl8, er8, ov8, idx8, sz8, if8.ram_wr, if8.ram_addr, if8.ram_data} !== '0) begin
            n_fail++; $display("FAIL rmid_outputs: got dl=%0b idx=%0d size=%0d wr=%0b want all 0", dl8, idx8, sz8, if8.ram_wr);
        end
        tick(2); @(negedge clk); reset = 1'b0; tick(2);
        ack8 = 1'b1; clear_log(); txb = '{8'h5A}; send_data(); tick(10); @(negedge clk);
        n_cmp++; if (w8a.size() != 0 || sz8 !== '0 || dl8 !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ignored: got n=%0d size=%0d dl=%0b want 0 0 0", w8a.size(), sz8, dl8);
        end
    endtask

    initial begin
        sck = 1'b0; ss = 1'b1; sdi = 1'b0; ack8 = 1'b1; ack16 = 1'b1; reset = 1'b1;
        test_reset();
        test_dl8();
        test_dl16();
        test_overflow();
        test_erase();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
